spi_rx_burst_master: RTL and testbench

Parametrised successor of the splitter serial reader.
- Master-side serial receiver: generates sclk_n and cs_n from the system clock using a programmable divider.
- Shifts in from_device MSB-first and delivers 1..2^BURST_W words of DATA_W bits per chip-select frame through a valid strobe.
- Sits between an external serial ADC/sensor and the on-chip stream logic; fully synchronous to clk.

---
 rtl/spi_rx_burst_master_if.sv | 29 ++
 rtl/spi_rx_burst_master.sv | 187 ++++++++++++++++++
 tb/tb_spi_rx_burst_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_burst_master_if.sv
// Control, serial-pin and word-stream signals of spi_rx_burst_master.
// master: the receiver itself; slave: the side that drives requests and serial data.
interface spi_rx_burst_master_if #(
   parameter int W       = 8,
   parameter int DATA_W  = 8,
   parameter int BURST_W = 4
);
   logic [W-1:0]       div;
   logic [BURST_W-1:0] burst_len;
   logic               start;
   logic               from_device;
   logic               sclk_n;
   logic               cs_n;
   logic [DATA_W-1:0]  data;
   logic               data_valid;
   logic               busy;
   logic               done;
   logic               parity_err;

   modport master (
      input  div, burst_len, start, from_device,
      output sclk_n, cs_n, data, data_valid, busy, done, parity_err
   );

   modport slave (
      output div, burst_len, start, from_device,
      input  sclk_n, cs_n, data, data_valid, busy, done, parity_err
   );
endinterface

// File: rtl/spi_rx_burst_master.sv
// Serial burst receiver: frames cs_n/sclk_n, shifts in MSB-first words and strobes them out.
// Optional odd-parity bit per word when SPI_RX_PARITY_EN is defined.
module spi_rx_burst_master #(
   parameter int W       = 8,
   parameter int DATA_W  = 8,
   parameter int BURST_W = 4,
   parameter int CS_GAP  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_rx_burst_master_if.master bus
);

`ifdef SPI_RX_PARITY_EN
   localparam int NBITS = DATA_W + 1;
`else
   localparam int NBITS = DATA_W;
`endif
   localparam int BCW = $clog2(NBITS);
   localparam int GW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
   localparam logic [GW-1:0]  GAP_LOAD = GW'(CS_GAP - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        div_q, div_d;
   logic [W-1:0]        cnt_q, cnt_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [BCW-1:0]      bit_q, bit_d;
   logic [BURST_W-1:0]  words_q, words_d;
   logic                hi_q, hi_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                dv_q, dv_d;
   logic                done_q, done_d;
`ifdef SPI_RX_PARITY_EN
   logic                perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         bit_q   <= '0;
         words_q <= '0;
         hi_q    <= 1'b0;
         sh_q    <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         words_q <= words_d;
         hi_q    <= hi_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         done_q  <= done_d;
`ifdef SPI_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // cnt_q counts div..0, so each phase lasts div+1 cycles without a W+1-bit counter.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      bit_d   = bit_q;
      words_d = words_q;
      hi_d    = hi_q;
      sh_d    = sh_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      done_d  = 1'b0;
`ifdef SPI_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SETUP;
               div_d   = bus.div;
               cnt_d   = bus.div;
               words_d = bus.burst_len;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = SHIFT;
               cnt_d   = div_q;
               hi_d    = 1'b0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = div_q;
               hi_d  = ~hi_q;
               if (!hi_q) begin
`ifdef SPI_RX_PARITY_EN
                  // The parity bit is checked against the completed word, not shifted in.
                  if (bit_q == LAST_BIT) begin
                     data_d = sh_q;
                     dv_d   = 1'b1;
                     perr_d = ~(^sh_q ^ bus.from_device);
                  end else begin
                     sh_d = {sh_q[DATA_W-2:0], bus.from_device};
                  end
`else
                  sh_d = {sh_q[DATA_W-2:0], bus.from_device};
                  if (bit_q == LAST_BIT) begin
                     data_d = sh_d;
                     dv_d   = 1'b1;
                  end
`endif
               end else if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (words_q == '0) begin
                     state_d = HOLD;
                  end else begin
                     words_d = words_q - 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               gap_d   = GAP_LOAD;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cs_n       = 1'b1;
      bus.sclk_n     = 1'b1;
      bus.busy       = (state_q != IDLE);
      bus.data       = data_q;
      bus.data_valid = dv_q;
      bus.done       = done_q;
`ifdef SPI_RX_PARITY_EN
      bus.parity_err = perr_q;
`else
      bus.parity_err = 1'b0;
`endif
      case (state_q)
         SETUP, HOLD: bus.cs_n = 1'b0;
         SHIFT: begin
            bus.cs_n   = 1'b0;
            bus.sclk_n = hi_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_rx_burst_master.sv
// Scoreboard bench for spi_rx_burst_master: random and directed frames, a serial slave model,
// and a monitor checking words, frame timing, sclk_n shape and the post-frame gap.
module tb_spi_rx_burst_master;
   localparam int W       = 8;
   localparam int DATA_W  = 8;
   localparam int BURST_W = 4;
   localparam int CS_GAP  = 2;
`ifdef SPI_RX_PARITY_EN
   localparam int NB = DATA_W + 1;
`else
   localparam int NB = DATA_W;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_rx_burst_master_if #(.W(W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

   spi_rx_burst_master #(
      .W(W), .DATA_W(DATA_W), .BURST_W(BURST_W), .CS_GAP(CS_GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] exp_data_q[$];
   logic              exp_perr_q[$];
   bit                bits_q[$];
   int                desc_h_q[$];
   int                desc_w_q[$];
   logic [DATA_W-1:0] wbuf[16];
   bit                pbuf[16];

   int cyc, frames_started, frames_done;
   int cur_h, cur_w, low_cnt, strobes, nfall, run, run_err, last_strobe;
   int high_cnt, bb_seen, gap_busy, stray;
   bit in_frame, gap_track, bb_mode, prev_cs, prev_sclk;

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Slave: present the next bit whenever the master drops sclk_n.
   initial begin
      bus.from_device = 1'b0;
      forever begin
         @(negedge bus.sclk_n);
         if (bits_q.size() > 0) bus.from_device = bits_q.pop_front();
         else bus.from_device = 1'b0;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         in_frame  = 1'b0;
         gap_track = 1'b0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b1;
         high_cnt  = 0;
         bb_seen   = 0;
      end else begin
         if (bus.data_valid) begin
            chk("strobe_in_frame", in_frame, 1);
            chk("strobe_expected", exp_data_q.size() > 0, 1);
            if (exp_data_q.size() > 0) begin
               chk("data", bus.data, exp_data_q.pop_front());
               chk("parity_err", bus.parity_err, exp_perr_q.pop_front());
            end
            if (strobes > 0) chk("strobe_spacing", cyc - last_strobe, 2 * cur_h * NB);
            last_strobe = cyc;
            strobes++;
         end else if (bus.parity_err) begin
            stray++;
         end

         if (prev_cs && !bus.cs_n) begin
            if (bb_mode && bb_seen > 0) chk("cs_high_between_frames", high_cnt, CS_GAP + 1);
            chk("frame_expected", desc_h_q.size() > 0, 1);
            if (desc_h_q.size() > 0) begin
               cur_h = desc_h_q.pop_front();
               cur_w = desc_w_q.pop_front();
            end
            in_frame = 1'b1;
            low_cnt  = 0;
            strobes  = 0;
            nfall    = 0;
            run      = 0;
            run_err  = 0;
            frames_started++;
         end

         if (!prev_cs && bus.cs_n && in_frame) begin
            chk("cs_low_len", low_cnt, cur_h * (2 + 2 * NB * cur_w));
            chk("done_at_cs_rise", bus.done, 1);
            chk("strobe_count", strobes, cur_w);
            chk("sclk_periods", nfall, NB * cur_w);
            chk("sclk_low_runs_bad", run_err, 0);
            in_frame  = 1'b0;
            gap_track = 1'b1;
            gap_busy  = 0;
            high_cnt  = 0;
            frames_done++;
            if (bb_mode) bb_seen++;
         end else if (bus.done) begin
            stray++;
         end

         if (!bus.cs_n) begin
            low_cnt++;
            if (prev_sclk && !bus.sclk_n) nfall++;
            if (!bus.sclk_n) run++;
            else if (!prev_sclk) begin
               if (run != cur_h) run_err++;
               run = 0;
            end
         end else begin
            high_cnt++;
         end

         if (gap_track) begin
            if (bus.busy) gap_busy++;
            else begin
               chk("busy_cycles_after_cs_rise", gap_busy, CS_GAP);
               gap_track = 1'b0;
            end
         end
         prev_cs   = bus.cs_n;
         prev_sclk = bus.sclk_n;
      end
      if (!bb_mode) bb_seen = 0;
   end

   task automatic push_frame(input int d, input int bl, input bit directed);
      logic [DATA_W-1:0] w;
`ifdef SPI_RX_PARITY_EN
      bit pb;
`endif
      desc_h_q.push_back(d + 1);
      desc_w_q.push_back(bl + 1);
      for (int i = 0; i <= bl; i++) begin
         w = directed ? wbuf[i] : DATA_W'($urandom);
         for (int b = DATA_W - 1; b >= 0; b--) bits_q.push_back(w[b]);
         exp_data_q.push_back(w);
`ifdef SPI_RX_PARITY_EN
         pb = directed ? pbuf[i] : 1'($urandom_range(0, 1));
         bits_q.push_back(pb);
         exp_perr_q.push_back((($countones(w) + int'(pb)) % 2) == 0);
`else
         exp_perr_q.push_back(1'b0);
`endif
      end
   endtask

   task automatic pulse_start(input int d, input int bl);
      bus.div       = W'(d);
      bus.burst_len = BURST_W'(bl);
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int limit);
      int n = 0;
      while ((frames_done < target || bus.busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("frame_finished_in_time", n < limit, 1);
   endtask

   task automatic run_frame(input int d, input int bl, input bit directed);
      int tgt = frames_done + 1;
      push_frame(d, bl, directed);
      pulse_start(d, bl);
      wait_frames(tgt, 2 * (d + 1) * (2 + 2 * NB * (bl + 1)) + 50);
   endtask

   task automatic test_ignore_midframe();
      int tgt = frames_done + 1;
      int fs  = frames_started;
      push_frame(3, 1, 0);
      pulse_start(3, 1);
      repeat (30) @(negedge clk);
      pulse_start(2, 5);
      wait_frames(tgt, 1000);
      repeat (20) @(negedge clk);
      chk("frames_after_busy_start", frames_started - fs, 1);
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      push_frame(1, 1, 0);
      pulse_start(1, 1);
      while (!(in_frame && nfall >= NB + 5) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reached_word1_bit4", n < 500, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_cs_n", bus.cs_n, 1);
      chk("rst_sclk_n", bus.sclk_n, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_data", bus.data, 0);
      chk("rst_data_valid", bus.data_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_words_outstanding", exp_data_q.size(), 1);
      rst_n = 1'b1;
      exp_data_q.delete();
      exp_perr_q.delete();
      bits_q.delete();
      desc_h_q.delete();
      desc_w_q.delete();
      repeat (40) @(negedge clk);
      chk("idle_after_rst_cs_n", bus.cs_n, 1);
   endtask

   task automatic test_back_to_back();
      int tgt = frames_done + 3;
      int fs  = frames_started + 3;
      int n   = 0;
      for (int k = 0; k < 3; k++) push_frame(1, 0, 0);
      bb_mode       = 1'b1;
      bus.div       = W'(1);
      bus.burst_len = '0;
      bus.start     = 1'b1;
      while (frames_started < fs && n < 2000) begin
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      chk("bb_frames_started", frames_started, fs);
      wait_frames(tgt, 500);
      bb_mode = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start     = 1'b0;
      bus.div       = '0;
      bus.burst_len = '0;
      bb_mode       = 1'b0;
      for (int i = 0; i < 16; i++) pbuf[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cs_n", bus.cs_n, 1);
      chk("reset_sclk_n", bus.sclk_n, 1);
      chk("reset_data", bus.data, 0);
      chk("reset_data_valid", bus.data_valid, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_parity_err", bus.parity_err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      wbuf[0] = 8'hA5;
      run_frame(6, 0, 1);
      wbuf[0] = 8'h3C;
      wbuf[1] = 8'hFF;
      wbuf[2] = 8'h01;
      run_frame(0, 2, 1);

      test_ignore_midframe();
      test_reset_midframe();
      test_back_to_back();

      run_frame(255, 0, 0);
      run_frame(0, 15, 0);
      for (int k = 0; k < 8; k++) run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 0);

`ifdef SPI_RX_PARITY_EN
      wbuf[0] = 8'h07;
      pbuf[0] = 1'b0;
      run_frame(1, 0, 1);
      pbuf[0] = 1'b1;
      run_frame(1, 0, 1);
`endif

      repeat (10) @(negedge clk);
      chk("stray_done_or_parity_err", stray, 0);
      chk("words_left_unreceived", exp_data_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
